command_decoder: RTL and testbench

//  Sits directly downstream of the host command interface. Consumes the registered commandToGpu/dataToGpu pair,

---
 rtl/command_decoder.sv | 177 +++++++++++++++++
 tb/tb_command_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/command_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : command_decoder
//  Description : Decodes and executes host commands: register file access,
//                framebuffer address setup, single-pixel writes and fills.
//  Revision    : 1.0  initial release
// ============================================================================

module command_decoder #(
    parameter int ADDR_WIDTH = 19,
    parameter int NUM_REGS   = 16
) (
    input  logic                     commandClk,
    input  logic                     resetN,
    input  logic [15:0]              commandToGpu,
    input  logic [15:0]              dataToGpu,
    output logic [15:0]              dataFromGpu,
    output logic                     busy,
    output logic                     cmdError,
    output logic                     fbWriteReq,
    input  logic                     fbWriteAck,
    output logic [ADDR_WIDTH-1:0]    fbAddr,
    output logic [15:0]              fbData,
    output logic [16*NUM_REGS-1:0]   regFlat
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_REG_WRITE = 4'h1;
    localparam logic [3:0] OP_REG_READ  = 4'h2;
    localparam logic [3:0] OP_ADDR_HI   = 4'h3;
    localparam logic [3:0] OP_ADDR_LO   = 4'h4;
    localparam logic [3:0] OP_PIXEL     = 4'h5;
    localparam logic [3:0] OP_FILL      = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             regs_q [NUM_REGS];
    logic [15:0]             regs_d [NUM_REGS];
    logic [ADDR_WIDTH-1:0]   addr_ptr_q, addr_ptr_d;
    logic [11:0]             fill_cnt_q, fill_cnt_d;
    logic [ADDR_WIDTH-1:0]   fb_addr_q, fb_addr_d;
    logic [15:0]             fb_data_q, fb_data_d;
    logic                    fb_req_q, fb_req_d;
    logic                    busy_q, busy_d;
    logic                    cmd_error_q, cmd_error_d;
    logic [15:0]             data_from_q, data_from_d;

    logic [3:0]              w_opcode;
    logic [11:0]             w_operand;
    logic [IDX_W-1:0]        w_reg_idx;
    logic                    w_cmd_valid;
    logic                    w_ack_hit;

    assign w_opcode    = commandToGpu[15:12];
    assign w_operand   = commandToGpu[11:0];
    assign w_reg_idx   = IDX_W'(32'(commandToGpu[3:0]) % NUM_REGS);
    assign w_cmd_valid = (commandToGpu != 16'h0000);
    assign w_ack_hit   = fb_req_q && fbWriteAck;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        addr_ptr_d  = addr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        fb_req_d    = fb_req_q;
        busy_d      = busy_q;
        cmd_error_d = 1'b0;
        data_from_d = data_from_q;

        case (state_q)
            ST_IDLE: begin
                if (w_cmd_valid) begin
                    case (w_opcode)
                        OP_NOP: ;
                        OP_REG_WRITE: regs_d[w_reg_idx] = dataToGpu;
                        OP_REG_READ:  data_from_d = regs_q[w_reg_idx];
                        OP_ADDR_HI:   addr_ptr_d[ADDR_WIDTH-1:16] = dataToGpu[ADDR_WIDTH-17:0];
                        OP_ADDR_LO:   addr_ptr_d[15:0] = dataToGpu;
                        OP_PIXEL: begin
                            fb_addr_d = addr_ptr_q;
                            fb_data_d = dataToGpu;
                            fb_req_d  = 1'b1;
                            busy_d    = 1'b1;
                            state_d   = ST_WRITE;
                        end
                        OP_FILL: begin
                            fill_cnt_d = w_operand;
                            // A zero-length fill is a no-op
                            if (w_operand != 12'd0) begin
                                fb_addr_d = addr_ptr_q;
                                fb_data_d = dataToGpu;
                                fb_req_d  = 1'b1;
                                busy_d    = 1'b1;
                                state_d   = ST_FILL;
                            end
                        end
                        default: cmd_error_d = 1'b1;
                    endcase
                end
            end
            ST_WRITE: begin
                cmd_error_d = w_cmd_valid;
                if (w_ack_hit) begin
                    fb_req_d   = 1'b0;
                    busy_d     = 1'b0;
                    addr_ptr_d = addr_ptr_q + ADDR_WIDTH'(1);
                    state_d    = ST_IDLE;
                end
            end
            ST_FILL: begin
                cmd_error_d = w_cmd_valid;
                if (w_ack_hit) begin
                    fill_cnt_d = fill_cnt_q - 12'd1;
                    addr_ptr_d = addr_ptr_q + ADDR_WIDTH'(1);
                    // Keep req high across beats so the fill streams without gaps
                    if (fill_cnt_q > 12'd1) begin
                        fb_addr_d = fb_addr_q + ADDR_WIDTH'(1);
                    end else begin
                        fb_req_d = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge commandClk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            regs_q      <= '{default: '0};
            addr_ptr_q  <= '0;
            fill_cnt_q  <= '0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            fb_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_error_q <= 1'b0;
            data_from_q <= '0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            addr_ptr_q  <= addr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            fb_req_q    <= fb_req_d;
            busy_q      <= busy_d;
            cmd_error_q <= cmd_error_d;
            data_from_q <= data_from_d;
        end
    end

    assign dataFromGpu = data_from_q;
    assign busy        = busy_q;
    assign cmdError    = cmd_error_q;
    assign fbWriteReq  = fb_req_q;
    assign fbAddr      = fb_addr_q;
    assign fbData      = fb_data_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regFlat[16*gi +: 16] = regs_q[gi];
    end

endmodule

`default_nettype wire

// File: tb/tb_command_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_command_decoder
//  Description : Directed self-checking bench for command_decoder.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_command_decoder;

    localparam int ADDR_WIDTH = 19;
    localparam int NUM_REGS   = 16;

    logic                    commandClk;
    logic                    resetN;
    logic [15:0]             commandToGpu;
    logic [15:0]             dataToGpu;
    logic [15:0]             dataFromGpu;
    logic                    busy;
    logic                    cmdError;
    logic                    fbWriteReq;
    logic                    fbWriteAck;
    logic [ADDR_WIDTH-1:0]   fbAddr;
    logic [15:0]             fbData;
    logic [16*NUM_REGS-1:0]  regFlat;

    int n_checks = 0;
    int n_pass   = 0;

    command_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_dut (
        .commandClk   (commandClk),
        .resetN       (resetN),
        .commandToGpu (commandToGpu),
        .dataToGpu    (dataToGpu),
        .dataFromGpu  (dataFromGpu),
        .busy         (busy),
        .cmdError     (cmdError),
        .fbWriteReq   (fbWriteReq),
        .fbWriteAck   (fbWriteAck),
        .fbAddr       (fbAddr),
        .fbData       (fbData),
        .regFlat      (regFlat)
    );

    initial commandClk = 1'b0;
    always #5 commandClk = ~commandClk;

    task automatic tick();
        @(posedge commandClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a command for exactly one edge, then return to no-command
    task automatic send(input logic [15:0] cmd, input logic [15:0] data);
        commandToGpu = cmd;
        dataToGpu    = data;
        tick();
        commandToGpu = 16'h0000;
        dataToGpu    = 16'h0000;
    endtask

    task automatic chk_fb(input string tag, input logic req, input logic bsy,
                          input logic [ADDR_WIDTH-1:0] addr);
        chk({tag, "_req"},  256'(fbWriteReq), 256'(req));
        chk({tag, "_busy"}, 256'(busy),       256'(bsy));
        chk({tag, "_addr"}, 256'(fbAddr),     256'(addr));
    endtask

    initial begin
        resetN       = 1'b0;
        commandToGpu = 16'h0000;
        dataToGpu    = 16'h0000;
        fbWriteAck   = 1'b0;

        // 1. reset
        repeat (3) tick();
        resetN = 1'b1;
        tick();
        chk("rst_dout",  256'(dataFromGpu), 256'h0);
        chk("rst_err",   256'(cmdError),    256'h0);
        chk_fb("rst", 1'b0, 1'b0, 19'h00000);
        chk("rst_data",  256'(fbData),      256'h0);
        chk("rst_regs",  256'(regFlat),     256'h0);

        // 2. register write / read
        send(16'h1003, 16'hBEEF);
        chk("reg3_write", 256'(regFlat), 256'hBEEF << 48);
        send(16'h2003, 16'h0000);
        chk("reg3_read",  256'(dataFromGpu), 256'hBEEF);
        tick();
        chk("read_hold",  256'(dataFromGpu), 256'hBEEF);

        // 3. pixel write with late ack
        send(16'h3000, 16'h0004);
        send(16'h4000, 16'hFFFF);
        send(16'h5000, 16'h1234);
        chk_fb("pix_e0", 1'b1, 1'b1, 19'h4FFFF);
        chk("pix_e0_data", 256'(fbData), 256'h1234);
        tick();
        chk_fb("pix_e1", 1'b1, 1'b1, 19'h4FFFF);
        tick();
        chk_fb("pix_e2", 1'b1, 1'b1, 19'h4FFFF);
        tick();
        chk_fb("pix_e3", 1'b1, 1'b1, 19'h4FFFF);
        chk("pix_e3_data", 256'(fbData), 256'h1234);
        fbWriteAck = 1'b1;
        tick();
        fbWriteAck = 1'b0;
        chk_fb("pix_done", 1'b0, 1'b0, 19'h4FFFF);
        send(16'h5000, 16'hAAAA);
        chk_fb("pix2", 1'b1, 1'b1, 19'h50000);
        chk("pix2_data", 256'(fbData), 256'hAAAA);
        fbWriteAck = 1'b1;
        tick();
        chk_fb("pix2_done", 1'b0, 1'b0, 19'h50000);

        // 4. back-to-back fill with ack tied high
        send(16'h3000, 16'h0000);
        send(16'h4000, 16'h0100);
        send(16'h6003, 16'hF800);
        chk_fb("fill_b0", 1'b1, 1'b1, 19'h00100);
        chk("fill_data", 256'(fbData), 256'hF800);
        tick();
        chk_fb("fill_b1", 1'b1, 1'b1, 19'h00101);
        tick();
        chk_fb("fill_b2", 1'b1, 1'b1, 19'h00102);
        tick();
        chk_fb("fill_end", 1'b0, 1'b0, 19'h00102);
        send(16'h6000, 16'h0000);
        chk_fb("fill0_a", 1'b0, 1'b0, 19'h00102);
        tick();
        chk_fb("fill0_b", 1'b0, 1'b0, 19'h00102);
        send(16'h5000, 16'h0001);
        chk_fb("after_fill_ptr", 1'b1, 1'b1, 19'h00103);
        tick();
        chk_fb("after_fill_done", 1'b0, 1'b0, 19'h00103);
        fbWriteAck = 1'b0;

        // 5. command dropped during a stalled fill, illegal opcode
        send(16'h6002, 16'h07E0);
        chk_fb("stall_b0", 1'b1, 1'b1, 19'h00104);
        send(16'h1005, 16'h5555);
        chk("drop_err",  256'(cmdError), 256'h1);
        chk_fb("stall_hold", 1'b1, 1'b1, 19'h00104);
        tick();
        chk("drop_err_pulse", 256'(cmdError), 256'h0);
        chk("drop_reg5", 256'(regFlat[16*5 +: 16]), 256'h0);
        fbWriteAck = 1'b1;
        tick();
        chk_fb("stall_b1", 1'b1, 1'b1, 19'h00105);
        tick();
        chk_fb("stall_end", 1'b0, 1'b0, 19'h00105);
        fbWriteAck = 1'b0;
        send(16'hF000, 16'h0000);
        chk("illegal_err", 256'(cmdError), 256'h1);
        send(16'h0123, 16'h0000);
        chk("nop_noerr",  256'(cmdError), 256'h0);
        chk("regs_kept",  256'(regFlat),  256'hBEEF << 48);

        // 6. address wrap, then reset in the middle of a fill
        send(16'h3000, 16'h0007);
        send(16'h4000, 16'hFFFF);
        fbWriteAck = 1'b1;
        send(16'h6002, 16'h001F);
        chk_fb("wrap_b0", 1'b1, 1'b1, 19'h7FFFF);
        tick();
        chk_fb("wrap_b1", 1'b1, 1'b1, 19'h00000);
        tick();
        chk_fb("wrap_end", 1'b0, 1'b0, 19'h00000);
        fbWriteAck = 1'b0;
        send(16'h6005, 16'h1111);
        chk_fb("rfill_b0", 1'b1, 1'b1, 19'h00001);
        fbWriteAck = 1'b1;
        tick();
        chk_fb("rfill_b1", 1'b1, 1'b1, 19'h00002);
        #2 resetN = 1'b0;
        #1;
        chk_fb("async_rst", 1'b0, 1'b0, 19'h00000);
        chk("async_rst_regs", 256'(regFlat), 256'h0);
        tick();
        resetN = 1'b1;
        tick();
        chk_fb("post_rst_a", 1'b0, 1'b0, 19'h00000);
        tick();
        chk_fb("post_rst_b", 1'b0, 1'b0, 19'h00000);
        fbWriteAck = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
